// File: rtl/mmss_timer.sv
// MM:SS stopwatch/countdown timer with run/pause/clear control and a done flag,
// driving a 4-digit multiplexed active-low 7-segment display.
module mmss_timer #(
  parameter int unsigned CLK_HZ      = 100_000_000,
  parameter int unsigned SCAN_HZ     = 1000,
  parameter int unsigned LIMIT_MIN   = 0,
  parameter int unsigned LIMIT_SEC   = 59,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic        clk,
  input  logic        btnC,
  input  logic        start_stop,
  input  logic        clear,
  input  logic        mode,
  output logic [3:0]  segEn,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [15:0] count_bcd,
  output logic        running,
  output logic        done
);

  localparam int unsigned SCAN_DIV_RAW = CLK_HZ / (4 * SCAN_HZ);
  localparam int unsigned SCAN_DIV     = (SCAN_DIV_RAW == 0) ? 1 : SCAN_DIV_RAW;
  localparam int unsigned PSC_W        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned SCAN_W       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PSC_W-1:0]  PSC_MAX  = PSC_W'(CLK_HZ - 1);
  localparam logic [SCAN_W-1:0] SCAN_MAX = SCAN_W'(SCAN_DIV - 1);
  localparam logic [15:0] LIMIT_BCD = {4'(LIMIT_MIN / 10), 4'(LIMIT_MIN % 10),
                                       4'(LIMIT_SEC / 10), 4'(LIMIT_SEC % 10)};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // BCD increment: seconds ones 0..9, seconds tens 0..5, minutes 00..99.
  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd9) begin
      r[3:0] = c[3:0] + 4'd1;
    end else begin
      r[3:0] = 4'd0;
      if (c[7:4] != 4'd5) begin
        r[7:4] = c[7:4] + 4'd1;
      end else begin
        r[7:4] = 4'd0;
        if (c[11:8] != 4'd9) begin
          r[11:8] = c[11:8] + 4'd1;
        end else begin
          r[11:8]  = 4'd0;
          r[15:12] = (c[15:12] != 4'd9) ? c[15:12] + 4'd1 : 4'd0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    r = c;
    if (c[3:0] != 4'd0) begin
      r[3:0] = c[3:0] - 4'd1;
    end else begin
      r[3:0] = 4'd9;
      if (c[7:4] != 4'd0) begin
        r[7:4] = c[7:4] - 4'd1;
      end else begin
        r[7:4] = 4'd5;
        if (c[11:8] != 4'd0) begin
          r[11:8] = c[11:8] - 4'd1;
        end else begin
          r[11:8]  = 4'd9;
          r[15:12] = (c[15:12] != 4'd0) ? c[15:12] - 4'd1 : 4'd9;
        end
      end
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a}; non-BCD codes blank the digit.
  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [15:0]       count_q, count_d;
  logic [PSC_W-1:0]  psc_q, psc_d;
  logic              done_q, done_d;
  logic              running_q, running_d;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0]        seg_en_q, seg_en_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;

  logic [15:0] start_c, term_c, step_c;
  logic [3:0]  digit_c;

  assign start_c = mode_q ? LIMIT_BCD : 16'h0000;
  assign term_c  = mode_q ? 16'h0000 : LIMIT_BCD;
  assign step_c  = mode_q ? bcd_dec(count_q) : bcd_inc(count_q);

  // Control FSM, prescaler and count; clear outranks start_stop, which outranks a tick.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    count_d = count_q;
    psc_d   = psc_q;
    done_d  = done_q;
    if (clear) begin
      state_d = ST_IDLE;
      count_d = start_c;
      psc_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          mode_d  = mode;
          count_d = mode ? LIMIT_BCD : 16'h0000;
          done_d  = 1'b0;
          if (start_stop) begin
            state_d = ST_RUN;
            psc_d   = '0;
          end
        end
        ST_RUN: begin
          done_d = 1'b0;
          if (start_stop) begin
            state_d = ST_PAUSE;
          end else if (psc_q == PSC_MAX) begin
            psc_d = '0;
            if (count_q == term_c) begin
              count_d = start_c;
            end else begin
              count_d = step_c;
              if (step_c == term_c) begin
                done_d = 1'b1;
                if (AUTO_RELOAD == 0) state_d = ST_DONE;
              end
            end
          end else begin
            psc_d = psc_q + PSC_W'(1);
          end
        end
        ST_PAUSE: begin
          if (start_stop) state_d = ST_RUN;
        end
        ST_DONE: begin
          done_d = 1'b1;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    running_d = (state_d == ST_RUN);
  end

  always_comb begin
    case (idx_q)
      2'd0:    digit_c = count_q[3:0];
      2'd1:    digit_c = count_q[7:4];
      2'd2:    digit_c = count_q[11:8];
      default: digit_c = count_q[15:12];
    endcase
  end

  // Display scan: enables, segments and colon all load on the same edge.
  always_comb begin
    scan_cnt_d = (scan_cnt_q == SCAN_MAX) ? '0 : scan_cnt_q + SCAN_W'(1);
    idx_d      = (scan_cnt_q == SCAN_MAX) ? idx_q + 2'd1 : idx_q;
    seg_en_d   = ~(4'b0001 << idx_q);
    seg_d      = seg_decode(digit_c);
    dp_d       = (idx_q != 2'd2);
  end

  always_ff @(posedge clk or posedge btnC) begin
    if (btnC) begin
      state_q    <= ST_IDLE;
      mode_q     <= 1'b0;
      count_q    <= 16'h0000;
      psc_q      <= '0;
      done_q     <= 1'b0;
      running_q  <= 1'b0;
      scan_cnt_q <= '0;
      idx_q      <= 2'd0;
      seg_en_q   <= 4'b1111;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      count_q    <= count_d;
      psc_q      <= psc_d;
      done_q     <= done_d;
      running_q  <= running_d;
      scan_cnt_q <= scan_cnt_d;
      idx_q      <= idx_d;
      seg_en_q   <= seg_en_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  assign segEn     = seg_en_q;
  assign seg       = seg_q;
  assign dp        = dp_q;
  assign count_bcd = count_q;
  assign running   = running_q;
  assign done      = done_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Bench for mmss_timer: a stop-at-limit instance (00:05) and an auto-reload instance (01:00)
// checked every cycle against a seconds-based reference model, plus directed spot values.
module tb_mmss_timer;

  localparam int unsigned CLK_HZ   = 8;
  localparam int unsigned SCAN_HZ  = 1;
  localparam int          SCAN_DIV = 2;
  localparam int P_IDLE = 0, P_RUN = 1, P_PAUSE = 2, P_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ss  = '0;
  logic [1:0] clr = '0;
  logic [1:0] md  = '0;

  logic [1:0][3:0]  seg_en_o;
  logic [1:0][6:0]  seg_o;
  logic [1:0]       dp_o;
  logic [1:0][15:0] cnt_o;
  logic [1:0]       run_o;
  logic [1:0]       done_o;

  int n_assert = 0;
  int n_fail   = 0;

  int lim [2] = '{5, 60};
  int ar  [2] = '{0, 1};
  int m_secs [2], m_prev [2], m_psc [2], m_phase [2], m_n [2];
  bit m_mode [2], m_done [2];

  always #5 clk = ~clk;

  mmss_timer #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .LIMIT_MIN(0), .LIMIT_SEC(5),
               .AUTO_RELOAD(0)) u_dut0 (
    .clk(clk), .btnC(rst), .start_stop(ss[0]), .clear(clr[0]), .mode(md[0]),
    .segEn(seg_en_o[0]), .seg(seg_o[0]), .dp(dp_o[0]), .count_bcd(cnt_o[0]),
    .running(run_o[0]), .done(done_o[0]));

  mmss_timer #(.CLK_HZ(CLK_HZ), .SCAN_HZ(SCAN_HZ), .LIMIT_MIN(1), .LIMIT_SEC(0),
               .AUTO_RELOAD(1)) u_dut1 (
    .clk(clk), .btnC(rst), .start_stop(ss[1]), .clear(clr[1]), .mode(md[1]),
    .segEn(seg_en_o[1]), .seg(seg_o[1]), .dp(dp_o[1]), .count_bcd(cnt_o[1]),
    .running(run_o[1]), .done(done_o[1]));

  function automatic logic [15:0] to_bcd(input int s);
    return {4'(s / 600), 4'((s / 60) % 10), 4'((s % 60) / 10), 4'(s % 10)};
  endfunction

  function automatic logic [6:0] seg7(input int d);
    logic [6:0] t [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    return t[d];
  endfunction

  function automatic int start_of(input int k, input bit m);
    return m ? lim[k] : 0;
  endfunction

  function automatic int term_of(input int k, input bit m);
    return m ? 0 : lim[k];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int k);
    m_secs[k] = 0; m_prev[k] = 0; m_psc[k] = 0; m_phase[k] = P_IDLE;
    m_n[k] = 0; m_mode[k] = 1'b0; m_done[k] = 1'b0;
  endtask

  task automatic model_step(input int k);
    m_prev[k] = m_secs[k];
    m_n[k]++;
    if (clr[k]) begin
      m_phase[k] = P_IDLE; m_secs[k] = start_of(k, m_mode[k]); m_psc[k] = 0; m_done[k] = 1'b0;
    end else begin
      case (m_phase[k])
        P_IDLE: begin
          m_mode[k] = md[k];
          m_secs[k] = start_of(k, md[k]);
          m_done[k] = 1'b0;
          if (ss[k]) begin m_phase[k] = P_RUN; m_psc[k] = 0; end
        end
        P_RUN: begin
          m_done[k] = 1'b0;
          if (ss[k]) m_phase[k] = P_PAUSE;
          else if (m_psc[k] == int'(CLK_HZ) - 1) begin
            m_psc[k] = 0;
            if (m_secs[k] == term_of(k, m_mode[k])) m_secs[k] = start_of(k, m_mode[k]);
            else begin
              m_secs[k] += m_mode[k] ? -1 : 1;
              if (m_secs[k] == term_of(k, m_mode[k])) begin
                m_done[k] = 1'b1;
                if (ar[k] == 0) m_phase[k] = P_DONE;
              end
            end
          end else m_psc[k]++;
        end
        P_PAUSE: if (ss[k]) m_phase[k] = P_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      int idx;
      logic [15:0] pb;
      logic [3:0] en;
      chk($sformatf("dut%0d count", k), cnt_o[k], to_bcd(m_secs[k]));
      chk($sformatf("dut%0d running", k), 16'(run_o[k]), 16'(m_phase[k] == P_RUN));
      chk($sformatf("dut%0d done", k), 16'(done_o[k]), 16'(m_done[k]));
      if (m_n[k] == 0) begin
        chk($sformatf("dut%0d segEn", k), 16'(seg_en_o[k]), 16'h000F);
        chk($sformatf("dut%0d seg", k), 16'(seg_o[k]), 16'h007F);
        chk($sformatf("dut%0d dp", k), 16'(dp_o[k]), 16'h0001);
      end else begin
        idx = ((m_n[k] - 1) / SCAN_DIV) % 4;
        pb  = to_bcd(m_prev[k]);
        en  = 4'b1111 ^ (4'b0001 << idx);
        chk($sformatf("dut%0d segEn", k), 16'(seg_en_o[k]), 16'(en));
        chk($sformatf("dut%0d seg", k), 16'(seg_o[k]), 16'(seg7(int'(pb[idx*4 +: 4]))));
        chk($sformatf("dut%0d dp", k), 16'(dp_o[k]), 16'(idx != 2));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) model_reset(k);
      else model_step(k);
    end
    #1 check_all();
    @(negedge clk);
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic pulse_ss(input int k);
    ss[k] = 1'b1; cycle(); ss[k] = 1'b0;
  endtask

  task automatic pulse_clr(input int k);
    clr[k] = 1'b1; cycle(); clr[k] = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++) model_reset(k);
    @(negedge clk);
    run(2);
    rst = 1'b0;

    // Up count to limit, hold in DONE, start_stop ignored, clear back to 00:00
    pulse_ss(0);
    run(8);
    chk("t1 first second", cnt_o[0], 16'h0001);
    run(32);
    chk("t1 at limit", cnt_o[0], 16'h0005);
    chk("t1 done", 16'(done_o[0]), 16'h0001);
    chk("t1 running", 16'(run_o[0]), 16'h0000);
    run(100);
    pulse_ss(0);
    chk("t1 held", cnt_o[0], 16'h0005);
    pulse_clr(0);
    chk("t1 cleared", cnt_o[0], 16'h0000);
    chk("t1 done cleared", 16'(done_o[0]), 16'h0000);

    // Down count; mode changes while running are ignored
    md[0] = 1'b1;
    cycle();
    chk("t2 down preload", cnt_o[0], 16'h0005);
    pulse_ss(0);
    md[0] = 1'b0;
    run(20);
    md[0] = 1'b1;
    run(20);
    chk("t2 reached zero", cnt_o[0], 16'h0000);
    chk("t2 done", 16'(done_o[0]), 16'h0001);
    pulse_clr(0);
    chk("t2 clear reloads limit", cnt_o[0], 16'h0005);
    md[0] = 1'b0;
    cycle();

    // Pause freezes count and prescaler
    pulse_ss(0);
    run(12);
    chk("t3 before pause", cnt_o[0], 16'h0001);
    pulse_ss(0);
    run(100);
    chk("t3 paused", cnt_o[0], 16'h0001);
    pulse_ss(0);
    run(3);
    chk("t3 resume +3", cnt_o[0], 16'h0001);
    cycle();
    chk("t3 resume +4", cnt_o[0], 16'h0002);
    pulse_clr(0);

    // Park 00:03 on the display while the reload instance counts through 01:00
    pulse_ss(0);
    run(24);
    pulse_ss(0);
    chk("t5 parked", cnt_o[0], 16'h0003);
    pulse_ss(1);
    run(472);
    chk("t4 0059", cnt_o[1], 16'h0059);
    run(8);
    chk("t4 carry to 0100", cnt_o[1], 16'h0100);
    chk("t4 done pulse", 16'(done_o[1]), 16'h0001);
    chk("t4 running", 16'(run_o[1]), 16'h0001);
    cycle();
    chk("t4 done drops", 16'(done_o[1]), 16'h0000);
    run(7);
    chk("t4 reload", cnt_o[1], 16'h0000);
    chk("t4 still running", 16'(run_o[1]), 16'h0001);
    pulse_clr(0);
    pulse_clr(1);

    // clear and start_stop together while running
    pulse_ss(0);
    run(10);
    ss[0] = 1'b1; clr[0] = 1'b1;
    cycle();
    ss[0] = 1'b0; clr[0] = 1'b0;
    chk("t6 collide count", cnt_o[0], 16'h0000);
    chk("t6 collide running", 16'(run_o[0]), 16'h0000);

    // Randomised pulses and mode changes on both instances
    for (int i = 0; i < 1200; i++) begin
      for (int k = 0; k < 2; k++) begin
        ss[k]  = ($urandom % 12) == 0;
        clr[k] = ($urandom % 90) == 0;
        md[k]  = 1'($urandom);
      end
      cycle();
    end
    ss = '0; clr = '0; md = '0;

    // Asynchronous reset between edges while running
    pulse_ss(0);
    pulse_ss(1);
    run(13);
    #2 rst = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("t6 async count%0d", k), cnt_o[k], 16'h0000);
      chk($sformatf("t6 async segEn%0d", k), 16'(seg_en_o[k]), 16'h000F);
      chk($sformatf("t6 async seg%0d", k), 16'(seg_o[k]), 16'h007F);
      chk($sformatf("t6 async dp%0d", k), 16'(dp_o[k]), 16'h0001);
      chk($sformatf("t6 async running%0d", k), 16'(run_o[k]), 16'h0000);
      chk($sformatf("t6 async done%0d", k), 16'(done_o[k]), 16'h0000);
      model_reset(k);
    end
    cycle();
    rst = 1'b0;
    run(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
